// File: rtl/actuation_voter.sv
// actuation_voter
//   M-of-N coincidence voter with persistence filtering, a static channel-to-
//   device map and sealed-in device outputs.
//
//   State    | meaning
//   ---------+------------------------------------------------------------
//   r_cnt[c] | consecutive cycles channel c has voted (saturates at PERSIST)
//   r_act[d] | device d sealed in; cleared only by reset_req_i[d]
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   trip_i       in   [NUM_CH*NUM_DIV] bit c*NUM_DIV+k: division k trips channel c
//   bypass_i     in   [NUM_DIV] division in maintenance bypass
//   manual_i     in   [NUM_DEV] manual actuation request
//   reset_req_i  in   [NUM_DEV] clear request for a sealed-in device
//   ch_trip_o    out  [NUM_CH] registered channel trip
//   act_o        out  [NUM_DEV] registered sealed-in actuation command
//   overbypass_o out  registered over-bypass indication
module actuation_voter #(
  parameter int NUM_DIV = 4,
  parameter int NUM_CH  = 3,
  parameter int VOTE_M  = 2,
  parameter int PERSIST = 3,
  parameter int NUM_DEV = 2,
  // bit [d*NUM_CH+c] set: channel c drives device d
  // default: dev1 <- ch2; dev0 <- ch0, ch1
  parameter logic [NUM_DEV*NUM_CH-1:0] DEV_MAP = 6'b100_011
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*NUM_DIV-1:0] trip_i,
  input  logic [NUM_DIV-1:0]        bypass_i,
  input  logic [NUM_DEV-1:0]        manual_i,
  input  logic [NUM_DEV-1:0]        reset_req_i,
  output logic [NUM_CH-1:0]         ch_trip_o,
  output logic [NUM_DEV-1:0]        act_o,
  output logic                      overbypass_o
);

  localparam int VW = $clog2(NUM_DIV + 1);
  localparam int PW = $clog2(PERSIST + 1);
  localparam logic [PW-1:0] P_MAX = PW'(PERSIST);

  generate
    if (VOTE_M > NUM_DIV) begin : g_bad_vote
      $error("actuation_voter: VOTE_M exceeds NUM_DIV");
    end
    if (PERSIST < 1) begin : g_bad_persist
      $error("actuation_voter: PERSIST must be at least 1");
    end
  endgenerate

  logic [VW-1:0]      w_byp_cnt;
  logic               w_ob;
  logic [VW-1:0]      w_votes    [NUM_CH];
  logic [NUM_CH-1:0]  w_vote;
  logic [PW-1:0]      w_cnt_next [NUM_CH];
  logic [NUM_CH-1:0]  w_hit_ch;
  logic [NUM_DEV-1:0] w_hit_dev;

  logic [PW-1:0]      r_cnt      [NUM_CH];
  logic [NUM_CH-1:0]  r_ch_trip;
  logic [NUM_DEV-1:0] r_act;
  logic               r_ob;

  always_comb begin
    w_byp_cnt = '0;
    for (int k = 0; k < NUM_DIV; k++) begin
      w_byp_cnt = w_byp_cnt + VW'(bypass_i[k]);
    end
    // Too many divisions bypassed to still reach VOTE_M: fail safe, vote all.
    w_ob = (int'(w_byp_cnt) > (NUM_DIV - VOTE_M));

    w_vote   = '0;
    w_hit_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_votes[c] = '0;
      for (int k = 0; k < NUM_DIV; k++) begin
        w_votes[c] = w_votes[c] + VW'(trip_i[c*NUM_DIV+k] & ~bypass_i[k]);
      end
      w_vote[c] = (int'(w_votes[c]) >= VOTE_M) | w_ob;
      if (!w_vote[c]) begin
        w_cnt_next[c] = '0;
      end else if (r_cnt[c] == P_MAX) begin
        w_cnt_next[c] = P_MAX;
      end else begin
        w_cnt_next[c] = r_cnt[c] + PW'(1);
      end
      w_hit_ch[c] = (w_cnt_next[c] == P_MAX);
    end

    w_hit_dev = '0;
    for (int d = 0; d < NUM_DEV; d++) begin
      w_hit_dev[d] = |(w_hit_ch & DEV_MAP[d*NUM_CH +: NUM_CH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
      end
      r_ch_trip <= '0;
      r_act     <= '0;
      r_ob      <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= w_cnt_next[c];
      end
      r_ch_trip <= w_hit_ch;
      // Trip or manual request takes priority over a simultaneous clear.
      r_act     <= w_hit_dev | manual_i | (r_act & ~reset_req_i);
      r_ob      <= w_ob;
    end
  end

  assign ch_trip_o    = r_ch_trip;
  assign act_o        = r_act;
  assign overbypass_o = r_ob;

endmodule

// File: tb/tb_actuation_voter.sv
// Testbench for actuation_voter: default instance plus a reduced
// 2-of-3, PERSIST=1 instance. Stimulus pushes expected outputs into a queue;
// a monitor pops one entry per clock edge and compares.
module tb_actuation_voter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [11:0] trip;
  logic [3:0]  byp;
  logic [1:0]  man;
  logic [1:0]  rr;
  logic [2:0]  ch_trip;
  logic [1:0]  act;
  logic        ob;

  logic [2:0]  s_trip;
  logic [2:0]  s_byp;
  logic [0:0]  s_man;
  logic [0:0]  s_rr;
  logic [0:0]  s_ch;
  logic [0:0]  s_act;
  logic        s_ob;

  typedef struct {
    logic [2:0] ch;
    logic [1:0] act;
    logic       ob;
    logic       s_ch;
    logic       s_act;
    logic       s_ob;
    string      nm;
  } exp_t;

  exp_t q[$];

  logic [2:0] e_ch;
  logic [1:0] e_act;
  logic       e_ob;
  logic       es_ch;
  logic       es_act;
  logic       es_ob;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  actuation_voter u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trip_i       (trip),
    .bypass_i     (byp),
    .manual_i     (man),
    .reset_req_i  (rr),
    .ch_trip_o    (ch_trip),
    .act_o        (act),
    .overbypass_o (ob)
  );

  actuation_voter #(
    .NUM_DIV (3),
    .NUM_CH  (1),
    .VOTE_M  (2),
    .PERSIST (1),
    .NUM_DEV (1),
    .DEV_MAP (1'b1)
  ) u_sweep (
    .clk          (clk),
    .rst_n        (rst_n),
    .trip_i       (s_trip),
    .bypass_i     (s_byp),
    .manual_i     (s_man),
    .reset_req_i  (s_rr),
    .ch_trip_o    (s_ch),
    .act_o        (s_act),
    .overbypass_o (s_ob)
  );

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic push_and_tick(input string nm);
    exp_t it;
    it.ch = e_ch; it.act = e_act; it.ob = e_ob;
    it.s_ch = es_ch; it.s_act = es_act; it.s_ob = es_ob;
    it.nm = nm;
    q.push_back(it);
    @(posedge clk);
    #2;
  endtask

  task automatic step(input logic [11:0] t, input logic [3:0] b, input logic [1:0] m,
                      input logic [1:0] r, input logic [2:0] ech, input logic [1:0] eact,
                      input logic eob, input string nm);
    trip = t; byp = b; man = m; rr = r;
    e_ch = ech; e_act = eact; e_ob = eob;
    es_ch = 1'b0; es_act = 1'b0; es_ob = 1'b0;
    push_and_tick(nm);
  endtask

  task automatic sstep(input logic [2:0] t, input logic [2:0] b, input logic m,
                       input logic r, input logic ech, input logic eact,
                       input logic eob, input string nm);
    trip = '0; byp = '0; man = '0; rr = '0;
    s_trip = t; s_byp = b; s_man = m; s_rr = r;
    e_ch = '0; e_act = '0; e_ob = 1'b0;
    es_ch = ech; es_act = eact; es_ob = eob;
    push_and_tick(nm);
  endtask

  // Monitor: outputs are registered, so sample 1 time unit after each edge.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk({it.nm, " ch_trip"},   4'(ch_trip), 4'(it.ch));
        chk({it.nm, " act"},       4'(act),     4'(it.act));
        chk({it.nm, " ob"},        4'(ob),      4'(it.ob));
        chk({it.nm, " sw ch_trip"}, 4'(s_ch),   4'(it.s_ch));
        chk({it.nm, " sw act"},    4'(s_act),   4'(it.s_act));
        chk({it.nm, " sw ob"},     4'(s_ob),    4'(it.s_ob));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    trip = '0; byp = '0; man = '0; rr = '0;
    s_trip = '0; s_byp = '0; s_man = '0; s_rr = '0;
    #12;
    chk("reset ch_trip", 4'(ch_trip), 4'h0);
    chk("reset act",     4'(act),     4'h0);
    chk("reset ob",      4'(ob),      4'h0);
    chk("reset sw act",  4'(s_act),   4'h0);
    #11 rst_n = 1'b1;

    // ch0 coincidence on div0+div2, then saturation
    step(12'h005, 4'h0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "ch0 e1");
    step(12'h005, 4'h0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "ch0 e2");
    step(12'h005, 4'h0, 2'b00, 2'b00, 3'b001, 2'b01, 1'b0, "ch0 e3");
    step(12'h005, 4'h0, 2'b00, 2'b00, 3'b001, 2'b01, 1'b0, "ch0 sat1");
    step(12'h005, 4'h0, 2'b00, 2'b00, 3'b001, 2'b01, 1'b0, "ch0 sat2");
    // seal-in and clear
    step(12'h000, 4'h0, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, "seal hold");
    step(12'h000, 4'h0, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0, "rr clear");
    step(12'h000, 4'h0, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0, "rr unsealed");
    // ch1: interrupted burst, then full burst
    step(12'h030, 4'h0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "ch1 b1 e1");
    step(12'h030, 4'h0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "ch1 b1 e2");
    step(12'h000, 4'h0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "ch1 gap");
    step(12'h030, 4'h0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "ch1 b2 e1");
    step(12'h030, 4'h0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "ch1 b2 e2");
    step(12'h030, 4'h0, 2'b00, 2'b00, 3'b010, 2'b01, 1'b0, "ch1 b2 e3");
    step(12'h000, 4'h0, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0, "ch1 rr");
    // trip with reset request held throughout
    step(12'h005, 4'h0, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0, "rr held e1");
    step(12'h005, 4'h0, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0, "rr held e2");
    step(12'h005, 4'h0, 2'b00, 2'b01, 3'b001, 2'b01, 1'b0, "rr held e3");
    step(12'h000, 4'h0, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0, "rr held drop");
    // bypass: div0 bypassed leaves one vote for ch2
    step(12'h300, 4'h1, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "byp1 e1");
    step(12'h300, 4'h1, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "byp1 e2");
    step(12'h300, 4'h1, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "byp1 e3");
    // two bypassed is still 2-of-2 capable: no over-bypass
    step(12'h300, 4'h3, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "byp2 e1");
    step(12'h300, 4'h3, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "byp2 e2");
    step(12'h300, 4'h3, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, "byp2 e3");
    // three bypassed: over-bypass forces every channel to vote
    step(12'h300, 4'h7, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, "byp3 e1");
    step(12'h300, 4'h7, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, "byp3 e2");
    step(12'h300, 4'h7, 2'b00, 2'b00, 3'b111, 2'b11, 1'b1, "byp3 e3");
    step(12'h000, 4'h0, 2'b00, 2'b11, 3'b000, 2'b00, 1'b0, "ob clear");
    // manual beats simultaneous reset request, then seals
    step(12'h000, 4'h0, 2'b10, 2'b10, 3'b000, 2'b10, 1'b0, "manual+rr");
    step(12'h000, 4'h0, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, "manual seal1");
    step(12'h000, 4'h0, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, "manual seal2");

    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async rst act",     4'(act),     4'h0);
    chk("async rst ch_trip", 4'(ch_trip), 4'h0);
    chk("async rst ob",      4'(ob),      4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // reduced configuration: 2-of-3, PERSIST=1
    sstep(3'b011, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "sw 2of3");
    sstep(3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "sw 1of3 rr");
    sstep(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sw 1of3");
    sstep(3'b110, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "sw byp1 2vote");
    sstep(3'b000, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "sw byp1 clear");
    sstep(3'b000, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "sw byp2 ob");

    repeat (2) @(posedge clk);
    #2;
    chk("queue drained", 4'(q.size()), 4'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
